// File: rtl/mat_frame_pkg.sv
// rtl/mat_frame_pkg.sv - shared constants, beat codes and FSM states for the matrix-loader frame
// Contents:
//   DEF_MAT_SIZE / DEF_DATA_W / DEF_DIM_BYTES - defaults shared with data_loader
//   ctrl_e  - beat type carried on ctrl_logic
//   state_e - transmitter FSM states
//   ctrl_of - beat type driven while in a given state
package mat_frame_pkg;

  localparam int DEF_MAT_SIZE  = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DIM_BYTES = 4;

  typedef enum logic [1:0] {
    CTRL_DATA = 2'd0,
    CTRL_DIM  = 2'd1,
    CTRL_MARK = 2'd2
  } ctrl_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DIM,
    DATA,
    END
  } state_e;

  function automatic ctrl_e ctrl_of(input state_e s);
    case (s)
      DIM:     return CTRL_DIM;
      DATA:    return CTRL_DATA;
      default: return CTRL_MARK;
    endcase
  endfunction

endpackage

// File: rtl/mat_tx_shreg.sv
// rtl/mat_tx_shreg.sv - payload shift register feeding the frame transmitter one byte per beat
// Ports:
//   CLK, RST_N - clock (rising edge), asynchronous active-low reset
//   load       - capture load_data (job accept)
//   load_data  - packed payload, first byte to send in the LSBs
//   shift      - consume the current byte (one DIM/DATA beat)
//   cur_byte   - byte that the current beat transmits
module mat_tx_shreg #(
  parameter int WIDTH  = 96,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              shift,
  output logic [DATA_W-1:0] cur_byte
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] src;

  // A load and a shift may coincide when a new job is accepted on the END
  // beat and the frame goes straight to DIM; the first byte then comes from
  // the incoming payload rather than the stale register.
  assign src      = load ? load_data : sh_q;
  assign cur_byte = src[DATA_W-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_q <= '0;
    end else if (load || shift) begin
      sh_q <= shift ? (src >> DATA_W) : src;
    end
  end

endmodule

// File: rtl/mat_frame_tx.sv
// rtl/mat_frame_tx.sv - serializes matrix jobs into START / DIM / DATA / END loader frames
// Optional feature macro: MAT_FRAME_TX_B2B_EN (accept on the END beat, END doubles as next START)
// Ports:
//   CLK, RST_N  - clock (rising edge), asynchronous active-low reset
//   in_valid    - job valid; held by the source until accepted
//   in_ready    - job can be accepted this cycle
//   in_dims     - dimension bytes, byte 0 in [7:0] sent first
//   in_mat_a    - matrix A, row-major, element 0 in LSBs
//   in_mat_b    - matrix B, same packing
//   ctrl_logic  - beat type: 0 data, 1 dimension, 2 marker
//   data_send   - beat payload
//   busy        - frame in progress (START through END)
//   frame_done  - one-cycle pulse on the END beat
module mat_frame_tx
  import mat_frame_pkg::*;
#(
  parameter int MAT_SIZE  = DEF_MAT_SIZE,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DIM_BYTES = DEF_DIM_BYTES
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIM_BYTES*DATA_W-1:0]   in_dims,
  input  logic [MAT_SIZE*DATA_W-1:0]    in_mat_a,
  input  logic [MAT_SIZE*DATA_W-1:0]    in_mat_b,
  output logic [1:0]                    ctrl_logic,
  output logic [DATA_W-1:0]             data_send,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int PAY_W   = (DIM_BYTES + 2*MAT_SIZE) * DATA_W;
  localparam int LONGEST = (DIM_BYTES > 2*MAT_SIZE) ? DIM_BYTES : 2*MAT_SIZE;
  localparam int CNT_W   = (LONGEST > 1) ? $clog2(LONGEST) : 1;

  localparam logic [CNT_W-1:0] DIM_LAST  = CNT_W'(DIM_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(2*MAT_SIZE - 1);

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             accept;
  logic             shift;
  logic             ready_d;
  logic [DATA_W-1:0] cur_byte;

  // in_ready is a registered output, so it already reflects the state the
  // outputs are showing this cycle.
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = START;
      START: state_d = DIM;
      DIM:   if (cnt == DIM_LAST) state_d = DATA;
      DATA:  if (cnt == DATA_LAST) state_d = END;
`ifdef MAT_FRAME_TX_B2B_EN
      END:   state_d = accept ? DIM : IDLE;
`else
      END:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Beat counter indexes the beat within DIM/DATA; it restarts on every
  // state change so each phase counts from zero.
  always_comb begin
    cnt_d = cnt;
    if (state_d != state) begin
      cnt_d = '0;
    end else if (state == DIM || state == DATA) begin
      cnt_d = cnt + 1'b1;
    end
  end

  assign shift = (state_d == DIM) || (state_d == DATA);

`ifdef MAT_FRAME_TX_B2B_EN
  assign ready_d = (state_d == IDLE) || (state_d == END);
`else
  assign ready_d = (state_d == IDLE);
`endif

  mat_tx_shreg #(
    .WIDTH  (PAY_W),
    .DATA_W (DATA_W)
  ) u_shreg (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (accept),
    .load_data ({in_mat_b, in_mat_a, in_dims}),
    .shift     (shift),
    .cur_byte  (cur_byte)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrl_logic <= CTRL_MARK;
      data_send  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ctrl_logic <= ctrl_of(state_d);
      data_send  <= shift ? cur_byte : '0;
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == END);
      in_ready   <= ready_d;
    end
  end

endmodule
